// File: rtl/skeeball_hold_timer_if.sv
// Sensor/status bundle for skeeball_hold_timer: the driver side is master, the timer is slave.
// remain packs one CW-bit count per channel, channel i at [i*CW +: CW].
interface skeeball_hold_timer_if #(
  parameter int NCH = 4,
  parameter int CW  = 3
);
  logic [NCH-1:0]    sense;
  logic              clr;
  logic [NCH-1:0]    active;
  logic [NCH-1:0]    done;
  logic [NCH*CW-1:0] remain;
  logic              tick;

  modport master (output sense, clr, input active, done, remain, tick);
  modport slave  (input sense, clr, output active, done, remain, tick);
endinterface

// File: rtl/skeeball_hold_timer.sv
// Multi-channel hold timer: each sensor edge holds active for HOLD prescaled ticks, then pulses done.
// Latency: active 3 clocks after sense rises. No backpressure. Macro: SKEEBALL_RETRIGGER_EN (edge in hold reloads).
module skeeball_hold_timer #(
  parameter int NCH  = 4,
  parameter int DIV  = 50000000,
  parameter int HOLD = 5
) (
  input  logic                  clk,
  input  logic                  Reset_n,
  skeeball_hold_timer_if.slave  bus
);
  localparam int CW  = $clog2(HOLD + 1);
  localparam int PCW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;

  logic [NCH-1:0] s1_q, s2_q, s3_q;
  logic [NCH-1:0] edge_w, retrig_w;
  logic [PCW-1:0] pc_q, pc_d;
  logic           tick_q, tick_d;
  state_t         st_q  [NCH];
  state_t         st_d  [NCH];
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [NCH-1:0] done_q, done_d;

  // Two-flop synchroniser plus a history flop for rising-edge detection
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= bus.sense;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_w = s2_q & ~s3_q;

`ifdef SKEEBALL_RETRIGGER_EN
  assign retrig_w = edge_w;
`else
  assign retrig_w = '0;
`endif

  always_comb begin
    tick_d = (pc_q == PCW'(DIV - 1));
    pc_d   = tick_d ? '0 : pc_q + PCW'(1);
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      tick_q <= tick_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i]  <= ST_IDLE;
        cnt_q[i] <= '0;
      end
      done_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      done_q <= done_d;
    end
  end

  // FSM next state; clr overrides everything, and an edge arriving in IDLE ignores a coincident tick
  always_comb begin
    done_d = '0;
    for (int i = 0; i < NCH; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      if (bus.clr) begin
        st_d[i]  = ST_IDLE;
        cnt_d[i] = '0;
      end else begin
        case (st_q[i])
          ST_IDLE: begin
            if (edge_w[i]) begin
              st_d[i]  = ST_HOLD;
              cnt_d[i] = CW'(HOLD);
            end else begin
              cnt_d[i] = '0;
            end
          end
          ST_HOLD: begin
            if (retrig_w[i]) begin
              cnt_d[i] = CW'(HOLD);
            end else if (tick_q) begin
              if (cnt_q[i] == CW'(1)) begin
                st_d[i]   = ST_IDLE;
                cnt_d[i]  = '0;
                done_d[i] = 1'b1;
              end else if (cnt_q[i] > CW'(1)) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
              end
            end
          end
          default: begin
            st_d[i]  = ST_IDLE;
            cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  // Outputs straight from the state registers
  always_comb begin
    bus.active = '0;
    bus.remain = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.active[i]            = (st_q[i] == ST_HOLD);
      bus.remain[i*CW +: CW]   = cnt_q[i];
    end
    bus.done = done_q;
    bus.tick = tick_q;
  end
endmodule
